// File: rtl/sequence_checker.sv
// sequence_checker
//
// Game-sequence engine for a Simon Says game. It holds a pseudo-random
// pattern of one-hot 4-bit symbols, plays the pattern back on the LEDs,
// checks each committed player entry against it and grows the pattern
// by one symbol every round until MAX_LEN is reached (win) or a wrong
// entry is seen (fail).
//
// Handshake: in_valid is a single-cycle qualifier for in_code. It is
// consumed only in the cycle where ready is high; pulses at any other
// time are dropped. start is a single-cycle pulse honoured only while
// idle, failed or won. When start and in_valid arrive together while
// waiting for entries, the entry is processed and start is dropped.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        pulse: begin a new game
//   in_valid     pulse: in_code holds a committed player entry
//   in_code      player code, expected one-hot
//   show_code    symbol being played back, 0 while blank
//   show_active  high for the whole playback (symbols and gaps)
//   ready        high while waiting for player entries
//   round        current sequence length, 0 when idle
//   fail         sticky lose flag
//   win          sticky win flag
//   state_dbg    current FSM state encoding (debug visibility)
module sequence_checker #(
  parameter int          MAX_LEN     = 16,
  parameter int          SHOW_CYCLES = 50_000_000,
  parameter int          GAP_CYCLES  = 12_500_000,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       in_valid,
  input  logic [3:0]                 in_code,
  output logic [3:0]                 show_code,
  output logic                       show_active,
  output logic                       ready,
  output logic [$clog2(MAX_LEN):0]   round,
  output logic                       fail,
  output logic                       win,
  output logic [2:0]                 state_dbg
);

  localparam int RW   = $clog2(MAX_LEN) + 1;
  localparam int IW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX = (SHOW_CYCLES > GAP_CYCLES) ? SHOW_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  // An all-zero seed would lock the LFSR up, so it is replaced by 1.
  localparam logic [7:0] SEED = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW     = 3'd1,
    S_GAP      = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_ROUND_OK = 3'd4,
    S_FAIL     = 3'd5,
    S_WIN      = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [3:0]      seq_q [MAX_LEN];
  logic [3:0]      seq_d [MAX_LEN];
  logic [RW-1:0]   round_q, round_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [3:0]      show_code_q, show_code_d;
  logic            show_active_q, show_active_d;
  logic            ready_q, ready_d;
  logic            fail_q, fail_d;
  logic            win_q, win_d;

  logic [3:0]      new_sym;
  logic            last_pos;

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    round_d = round_q;
    idx_d   = idx_q;
    timer_d = timer_q;

    // Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, free-running every cycle.
    lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    new_sym = 4'b0001 << lfsr_q[1:0];

    // True when idx points at the newest symbol of the current round.
    last_pos = (RW'(idx_q) == (round_q - RW'(1)));

    case (state_q)
      S_IDLE, S_FAIL, S_WIN: begin
        if (start) begin
          seq_d[0] = new_sym;
          round_d  = RW'(1);
          idx_d    = '0;
          timer_d  = '0;
          state_d  = S_SHOW;
        end
      end

      S_SHOW: begin
        if (timer_q == TW'(SHOW_CYCLES - 1)) begin
          timer_d = '0;
          state_d = S_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_GAP: begin
        if (timer_q == TW'(GAP_CYCLES - 1)) begin
          timer_d = '0;
          if (last_pos) begin
            idx_d   = '0;
            state_d = S_WAIT_IN;
          end else begin
            idx_d   = idx_q + IW'(1);
            state_d = S_SHOW;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end

      S_WAIT_IN: begin
        if (in_valid) begin
          // Stored symbols are always one-hot, so zero or multi-hot
          // entries can never match.
          if (in_code != seq_q[idx_q]) begin
            state_d = S_FAIL;
          end else if (last_pos) begin
            idx_d   = '0;
            state_d = S_ROUND_OK;
          end else begin
            idx_d   = idx_q + IW'(1);
          end
        end
      end

      S_ROUND_OK: begin
        if (round_q == RW'(MAX_LEN)) begin
          state_d = S_WIN;
        end else begin
          seq_d[round_q[IW-1:0]] = new_sym;
          round_d = round_q + RW'(1);
          idx_d   = '0;
          timer_d = '0;
          state_d = S_SHOW;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered
    // in the same cycle the state itself changes.
    show_active_d = (state_d == S_SHOW) || (state_d == S_GAP);
    show_code_d   = (state_d == S_SHOW) ? seq_d[idx_d] : 4'b0000;
    ready_d       = (state_d == S_WAIT_IN);
    fail_d        = (state_d == S_FAIL);
    win_d         = (state_d == S_WIN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      lfsr_q        <= SEED;
      for (int i = 0; i < MAX_LEN; i++) begin
        seq_q[i] <= 4'b0000;
      end
      round_q       <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
      show_code_q   <= 4'b0000;
      show_active_q <= 1'b0;
      ready_q       <= 1'b0;
      fail_q        <= 1'b0;
      win_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      lfsr_q        <= lfsr_d;
      seq_q         <= seq_d;
      round_q       <= round_d;
      idx_q         <= idx_d;
      timer_q       <= timer_d;
      show_code_q   <= show_code_d;
      show_active_q <= show_active_d;
      ready_q       <= ready_d;
      fail_q        <= fail_d;
      win_q         <= win_d;
    end
  end

  assign show_code   = show_code_q;
  assign show_active = show_active_q;
  assign ready       = ready_q;
  assign round       = round_q;
  assign fail        = fail_q;
  assign win         = win_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker with a short pattern and timers.
// Expected symbols come from a reference LFSR running alongside the DUT;
// the expected pattern of the current game lives in exp_q.
module tb_sequence_checker;

  localparam int         MAX_LEN     = 3;
  localparam int         SHOW_CYCLES = 4;
  localparam int         GAP_CYCLES  = 2;
  localparam logic [7:0] LFSR_SEED   = 8'hA5;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_ROUND_OK = 3'd4;
  localparam logic [2:0] ST_FAIL     = 3'd5;
  localparam logic [2:0] ST_WIN      = 3'd6;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [3:0] in_code;
  logic [3:0] show_code;
  logic       show_active;
  logic       ready;
  logic [2:0] round;
  logic       fail;
  logic       win;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  sequence_checker #(
    .MAX_LEN    (MAX_LEN),
    .SHOW_CYCLES(SHOW_CYCLES),
    .GAP_CYCLES (GAP_CYCLES),
    .LFSR_SEED  (LFSR_SEED)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_code    (in_code),
    .show_code  (show_code),
    .show_active(show_active),
    .ready      (ready),
    .round      (round),
    .fail       (fail),
    .win        (win),
    .state_dbg  (state_dbg)
  );

  // Reference LFSR: x^8+x^6+x^5+x^4+1, shifting left, reloads on reset.
  logic [7:0] m_lfsr;
  always @(posedge clk) begin
    if (reset) m_lfsr <= LFSR_SEED;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // ---------------- scoreboard ----------------
  logic [3:0] exp_q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  logic [3:0] g1_0, g1_1;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    exp_q.delete();
    exp_q.push_back(4'b0001 << m_lfsr[1:0]);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_round", 16'(round), 16'd1);
    chk("start_fail", 16'(fail), 16'd0);
    chk("start_win", 16'(win), 16'd0);
  endtask

  // Checks a full playback of n symbols starting at the first SHOW cycle.
  // With noise set, in_valid is pulsed every cycle with the shown symbol.
  task automatic play(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < SHOW_CYCLES; c++) begin
        chk("show_active", 16'(show_active), 16'd1);
        chk("show_code", 16'(show_code), 16'(exp_q[i]));
        chk("show_ready", 16'(ready), 16'd0);
        in_valid = noise;
        in_code  = exp_q[i];
        tick();
      end
      for (int c = 0; c < GAP_CYCLES; c++) begin
        chk("gap_active", 16'(show_active), 16'd1);
        chk("gap_code", 16'(show_code), 16'd0);
        chk("gap_ready", 16'(ready), 16'd0);
        in_valid = noise;
        in_code  = exp_q[i];
        tick();
      end
    end
    in_valid = 1'b0;
    in_code  = 4'b0000;
    chk("wait_ready", 16'(ready), 16'd1);
    chk("wait_round", 16'(round), 16'(n));
    chk("wait_active", 16'(show_active), 16'd0);
    chk("wait_code", 16'(show_code), 16'd0);
  endtask

  task automatic enter(input logic [3:0] code);
    in_valid = 1'b1;
    in_code  = code;
    tick();
    in_valid = 1'b0;
    in_code  = 4'b0000;
  endtask

  // Enters the whole expected pattern of round n; then either moves on to
  // the next round's playback or, at MAX_LEN, steps into the win state.
  task automatic advance(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      enter(exp_q[i]);
      if (i < n - 1) chk("mid_ready", 16'(ready), 16'd1);
    end
    chk("rok_ready", 16'(ready), 16'd0);
    chk("rok_active", 16'(show_active), 16'd0);
    chk("rok_state", 16'(state_dbg), 16'(ST_ROUND_OK));
    if (n < MAX_LEN) begin
      exp_q.push_back(4'b0001 << m_lfsr[1:0]);
      tick();
      chk("next_round", 16'(round), 16'(n + 1));
      play(n + 1, noise);
    end else begin
      tick();
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_code"}, 16'(show_code), 16'd0);
    chk({tag, "_active"}, 16'(show_active), 16'd0);
    chk({tag, "_ready"}, 16'(ready), 16'd0);
    chk({tag, "_round"}, 16'(round), 16'd0);
    chk({tag, "_fail"}, 16'(fail), 16'd0);
    chk({tag, "_win"}, 16'(win), 16'd0);
    chk({tag, "_state"}, 16'(state_dbg), 16'(ST_IDLE));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_code  = 4'b0000;

    // 1: reset, idle, first round playback
    tick();
    tick();
    chk_all_zero("rst");
    reset = 1'b0;
    tick(); tick(); tick();
    chk("idle_round", 16'(round), 16'd0);
    chk("idle_active", 16'(show_active), 16'd0);
    pulse_start();
    g1_0 = exp_q[0];
    play(1, 1'b0);

    // 2: correct entry grows the pattern to two symbols
    advance(1, 1'b0);
    g1_1 = exp_q[1];

    // 3: second entry wrong
    enter(exp_q[0]);
    chk("r2_ready", 16'(ready), 16'd1);
    enter({exp_q[1][2:0], exp_q[1][3]});
    chk("fail_flag", 16'(fail), 16'd1);
    chk("fail_ready", 16'(ready), 16'd0);
    chk("fail_round", 16'(round), 16'd2);
    chk("fail_state", 16'(state_dbg), 16'(ST_FAIL));
    enter(4'b0001);
    enter(4'b0010);
    tick();
    chk("fail_hold", 16'(fail), 16'd1);
    chk("fail_hold_round", 16'(round), 16'd2);
    chk("fail_hold_active", 16'(show_active), 16'd0);
    pulse_start();
    play(1, 1'b0);

    // 4: play through to a win
    advance(1, 1'b0);
    advance(2, 1'b0);
    advance(3, 1'b0);
    chk("win_flag", 16'(win), 16'd1);
    chk("win_round", 16'(round), 16'd3);
    chk("win_ready", 16'(ready), 16'd0);
    chk("win_active", 16'(show_active), 16'd0);
    chk("win_state", 16'(state_dbg), 16'(ST_WIN));
    enter(exp_q[0]);
    tick(); tick(); tick();
    chk("win_hold", 16'(win), 16'd1);
    chk("win_hold_round", 16'(round), 16'd3);
    chk("win_hold_fail", 16'(fail), 16'd0);

    // 5: in_valid during playback is ignored; bad codes fail
    pulse_start();
    play(1, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_ignored_ready", 16'(ready), 16'd1);
    chk("start_ignored_round", 16'(round), 16'd1);
    enter(4'b0000);
    chk("zero_code_fail", 16'(fail), 16'd1);
    pulse_start();
    play(1, 1'b1);
    // start alongside the entry: the entry wins, start is dropped
    start = 1'b1;
    enter(exp_q[0]);
    start = 1'b0;
    chk("both_ready", 16'(ready), 16'd0);
    chk("both_fail", 16'(fail), 16'd0);
    chk("both_round", 16'(round), 16'd1);
    chk("both_state", 16'(state_dbg), 16'(ST_ROUND_OK));
    exp_q.push_back(4'b0001 << m_lfsr[1:0]);
    tick();
    play(2, 1'b1);
    enter(exp_q[0]);
    enter(4'b0011);
    chk("multi_code_fail", 16'(fail), 16'd1);
    chk("multi_code_round", 16'(round), 16'd2);

    // 6: reset in the middle of round-2 playback
    pulse_start();
    play(1, 1'b0);
    enter(exp_q[0]);
    tick();
    tick();
    chk("pre_reset_active", 16'(show_active), 16'd1);
    reset = 1'b1;
    tick();
    chk_all_zero("midrst");
    tick();
    reset = 1'b0;
    tick(); tick(); tick();
    // Same timing as the first game, so the same symbols must appear.
    exp_q.delete();
    exp_q.push_back(g1_0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("replay_round", 16'(round), 16'd1);
    play(1, 1'b0);
    enter(exp_q[0]);
    chk("replay_rok", 16'(state_dbg), 16'(ST_ROUND_OK));
    exp_q.push_back(g1_1);
    tick();
    play(2, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected end of test");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sequence_checker.md
Name: sequence_checker

Overview:
- Game-sequence engine for Simon Says; sits directly downstream of the switch-input block.
- Consumes committed 4-bit player codes, holds the pseudo-random pattern, plays it back on LEDs, and checks each player entry.
- Reports round number, fail and win to the display/top level.

Parameters:
MAX_LEN, 16, maximum sequence length; reaching it with all entries correct is a win.
SHOW_CYCLES, 50_000_000, clock cycles each symbol is displayed during playback.
GAP_CYCLES, 12_500_000, blank clock cycles after each displayed symbol.
LFSR_SEED, 8'hA5, LFSR reset value; 8'h00 is replaced by 8'h01.

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begins a new game (honoured only in IDLE, FAIL or WIN)
in_valid  input  1  one-cycle pulse: in_code holds a committed player entry
in_code  input  4  player code, one-hot (0001/0010/0100/1000)
show_code  output  4  symbol being played back; 0000 when blank
show_active  output  1  high throughout playback (symbols and gaps)
ready  output  1  high while waiting for player entries
round  output  $clog2(MAX_LEN)+1  current sequence length, 0 in IDLE
fail  output  1  sticky lose flag
win  output  1  sticky win flag

Behaviour:
- Reset (sync, active-high, overrides everything, including mid-playback):
  - state IDLE.
  - All outputs 0.
  - LFSR = LFSR_SEED (or 8'h01 if the seed is 0).
  - Position index and timers cleared.
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Steps every cycle when not in reset.
  - New symbol = 4'b0001 << lfsr[1:0], sampled at the moment of append.
- Sequence storage: MAX_LEN x 4-bit register array.
- States: IDLE, SHOW, GAP, WAIT_IN, ROUND_OK, FAIL, WIN.
- IDLE/FAIL/WIN + start:
  - seq[0] = new symbol; round = 1.
  - fail = 0, win = 0, idx = 0, timer = 0.
  - Next state SHOW.
- SHOW:
  - show_code = seq[idx], show_active = 1.
  - After SHOW_CYCLES cycles -> GAP.
- GAP:
  - show_code = 0, show_active = 1.
  - After GAP_CYCLES cycles: if idx == round-1 then idx = 0 -> WAIT_IN; else idx++ -> SHOW.
- WAIT_IN:
  - ready = 1, show_active = 0.
  - On in_valid, in_code is compared to seq[idx] in the same cycle.
  - Mismatch (including 0000 or a non-one-hot code) -> FAIL.
  - Match with idx < round-1 -> idx++, stay in WAIT_IN.
  - Match with idx == round-1 -> ROUND_OK.
- ROUND_OK (one cycle, ready = 0):
  - If round == MAX_LEN -> WIN.
  - Else seq[round] = new symbol, round++, idx = 0 -> SHOW.
- FAIL: fail = 1, ready = 0; round holds its value.
- WIN: win = 1, ready = 0; round = MAX_LEN.
- in_valid outside WAIT_IN is ignored, with no effect on state.
- start outside IDLE/FAIL/WIN is ignored.
- start and in_valid in the same cycle in WAIT_IN: in_valid is processed, start is ignored.
- All outputs are registered.
- Latency:
  - start -> show_active high on the next cycle.
  - Last matching in_valid -> ready low on the next cycle, show_active high two cycles after it.
  - Mismatching in_valid -> fail high on the next cycle.
- Timers:
  - Width is $clog2(max(SHOW_CYCLES, GAP_CYCLES)).
  - Count 0 to N-1, then clear on each state change.

Test Plan (SHOW_CYCLES=4, GAP_CYCLES=2, MAX_LEN=3):
1. Reset, then start pulse at cycle 0:
   - All outputs 0 during reset.
   - Cycles 1-4: show_active = 1, show_code one-hot constant.
   - Cycles 5-6: show_code = 0.
   - Cycle 7: ready = 1, round = 1.
2. Enter the captured symbol:
   - round = 2.
   - Playback shows the round-1 symbol (4 cycles), 2-cycle gap, a new symbol (4 cycles), 2-cycle gap.
   - ready rises afterwards.
3. Wrong code in round 2 (second entry wrong):
   - Next cycle fail = 1, ready = 0, round = 2.
   - Further in_valid has no effect.
   - start restarts with fail = 0, round = 1.
4. Enter correct sequences for rounds 1, 2 and 3:
   - After the final entry, win = 1, round = 3, ready = 0, show_active = 0, and this holds until start.
5. in_valid pulses during SHOW/GAP are ignored and playback timing is unchanged. in_code = 0000 or 0011 in WAIT_IN gives fail = 1.
6. Reset asserted mid-SHOW in round 2:
   - Next cycle all outputs are 0 and state is IDLE.
   - A subsequent start replays from round 1, using the symbol sequence restarted from LFSR_SEED.
